// File: rtl/score_bcd.sv
// Converts two binary scores to three BCD digits each via parallel double-dabble; done SCORE_W+2 cycles after start.
// Optional SCORE_BCD_LEADING_ZERO_BLANK_EN blanks leading zeros (4'hF). start is ignored while busy.
module score_bcd #(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [SCORE_W-1:0] score_a,
    input  logic [SCORE_W-1:0] score_b,
    output logic               busy,
    output logic               done,
    output logic [3:0]         seg0,
    output logic [3:0]         seg1,
    output logic [3:0]         seg2,
    output logic [3:0]         seg3,
    output logic [3:0]         seg4,
    output logic [3:0]         seg5
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

`ifdef SCORE_BCD_LEADING_ZERO_BLANK_EN
    localparam logic [11:0] RST_DIG = 12'hFF0;
`else
    localparam logic [11:0] RST_DIG = 12'h000;
`endif

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0] sra_q, sra_d, srb_q, srb_d;
    logic [11:0]        bcda_q, bcda_d, bcdb_q, bcdb_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [5:0][3:0]    seg_q, seg_d;

    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return 12'({adj, bit_in});
    endfunction

    function automatic logic [11:0] blank(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
`ifdef SCORE_BCD_LEADING_ZERO_BLANK_EN
        if (bcd[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (bcd[7:4] == 4'd0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sra_d   = sra_q;
        srb_d   = srb_q;
        bcda_d  = bcda_q;
        bcdb_d  = bcdb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        seg_d   = seg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sra_d   = score_a;
                    srb_d   = score_b;
                    bcda_d  = '0;
                    bcdb_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // MSB of each captured score feeds the LSB of its BCD accumulator.
                bcda_d = dd_step(bcda_q, sra_q[SCORE_W-1]);
                bcdb_d = dd_step(bcdb_q, srb_q[SCORE_W-1]);
                sra_d  = sra_q << 1;
                srb_d  = srb_q << 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(SCORE_W - 1)) state_d = DONE;
            end
            DONE: begin
                seg_d   = {blank(bcdb_q), blank(bcda_q)};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sra_q   <= '0;
            srb_q   <= '0;
            bcda_q  <= '0;
            bcdb_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= {RST_DIG, RST_DIG};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sra_q   <= sra_d;
            srb_q   <= srb_d;
            bcda_q  <= bcda_d;
            bcdb_q  <= bcdb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];

endmodule
